// File: rtl/tdp_bram_mode.sv
// ---------------------------------------------------------------------------
// tdp_bram_mode
//
// True dual-port block RAM with two independent read/write ports on a single
// clock. It provides:
//   - byte write enables
//   - a write mode per port (WRITE_FIRST / READ_FIRST / NO_CHANGE)
//   - defined behaviour when both ports hit the same address
//   - read-valid strobes
//   - a collision pulse with a saturating collision counter
//
// Optional build macro:
//   TDP_OUT_REG_EN - adds a second output register stage per port, so read
//                    latency becomes 2. The collision pulse timing does not
//                    change.
//
// Ports:
//   clk      in   1          single clock, rising edge
//   rst_n    in   1          synchronous active-low reset
//   ena      in   1          port A enable
//   wea      in   NB         port A byte write enables (all zero = read)
//   addra    in   LOG        port A address
//   dina     in   RAM_WIDTH  port A write data
//   douta    out  RAM_WIDTH  port A read data
//   valida   out  1          douta updated this cycle
//   enb/web/addrb/dinb/doutb/validb   same as port A, for port B
//   coll     out  1          one-cycle pulse after a same-address collision
//   coll_cnt out  16         saturating count of collisions since reset
//
// Handshake: a request is one cycle with en=1. There is no back-pressure.
// valid marks the cycle in which dout carries that request's data.
// ---------------------------------------------------------------------------
module tdp_bram_mode #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 1024,
    parameter int LOG       = 10,
    parameter int BYTE_W    = 8,
    parameter int MODE_A    = 0,
    parameter int MODE_B    = 1,
    parameter int COLL_PRIO = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [RAM_WIDTH/BYTE_W-1:0]   wea,
    input  logic [LOG-1:0]                addra,
    input  logic [RAM_WIDTH-1:0]          dina,
    output logic [RAM_WIDTH-1:0]          douta,
    output logic                          valida,
    input  logic                          enb,
    input  logic [RAM_WIDTH/BYTE_W-1:0]   web,
    input  logic [LOG-1:0]                addrb,
    input  logic [RAM_WIDTH-1:0]          dinb,
    output logic [RAM_WIDTH-1:0]          doutb,
    output logic                          validb,
    output logic                          coll,
    output logic [15:0]                   coll_cnt
);

    localparam int             NB      = RAM_WIDTH / BYTE_W;
    localparam logic [LOG:0]   DEPTH_L = (LOG+1)'(RAM_DEPTH);

    // Memory array. It has no reset; contents start at zero at configuration.
    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];

    // Overlay the enabled bytes of new_w onto old_w.
    function automatic logic [RAM_WIDTH-1:0] f_merge(
        input logic [RAM_WIDTH-1:0] old_w,
        input logic [RAM_WIDTH-1:0] new_w,
        input logic [NB-1:0]        be
    );
        logic [RAM_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    // Request decode. Out-of-range addresses behave like an idle port.
    logic                 w_va, w_vb;
    logic                 w_wr_a, w_wr_b;
    logic                 w_same, w_coll;
    logic [NB-1:0]        w_mask_a, w_mask_b;
    logic [RAM_WIDTH-1:0] w_old_a, w_old_b;
    logic [RAM_WIDTH-1:0] w_fin_a, w_fin_b, w_fin_both;

    assign w_va     = ena && ({1'b0, addra} < DEPTH_L);
    assign w_vb     = enb && ({1'b0, addrb} < DEPTH_L);
    // Writes issued during a reset cycle are dropped.
    assign w_wr_a   = rst_n && w_va && (|wea);
    assign w_wr_b   = rst_n && w_vb && (|web);
    assign w_mask_a = w_wr_a ? wea : '0;
    assign w_mask_b = w_wr_b ? web : '0;
    assign w_same   = w_va && w_vb && (addra == addrb);
    assign w_coll   = rst_n && w_same && (w_wr_a || w_wr_b);

    assign w_old_a  = r_mem[addra];
    assign w_old_b  = r_mem[addrb];

    // Same-address result: the losing port is merged first, so the winner's
    // bytes overwrite it wherever both ports enabled the same byte.
    always_comb begin
        w_fin_both = w_old_a;
        if (COLL_PRIO == 0) begin
            w_fin_both = f_merge(f_merge(w_old_a, dinb, w_mask_b), dina, w_mask_a);
        end else begin
            w_fin_both = f_merge(f_merge(w_old_a, dina, w_mask_a), dinb, w_mask_b);
        end
    end

    assign w_fin_a = w_same ? w_fin_both : f_merge(w_old_a, dina, w_mask_a);
    assign w_fin_b = w_same ? w_fin_both : f_merge(w_old_b, dinb, w_mask_b);

    // Storage update. When both ports write the same address they store the
    // same merged word, so the order of the two assignments does not matter.
    always_ff @(posedge clk) begin
        if (w_wr_a) begin
            r_mem[addra] <= w_fin_a;
        end
        if (w_wr_b) begin
            r_mem[addrb] <= w_fin_b;
        end
    end

    // First output stage, one per port. A read always returns the word as it
    // was before any same-cycle write, which gives the read-write collision
    // its old-data result.
    logic [RAM_WIDTH-1:0] r_douta1, r_doutb1;
    logic                 r_valida1, r_validb1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_douta1  <= '0;
            r_valida1 <= 1'b0;
        end else if (w_va && !w_wr_a) begin
            r_douta1  <= w_old_a;
            r_valida1 <= 1'b1;
        end else if (w_wr_a && MODE_A == 0) begin
            r_douta1  <= w_fin_a;
            r_valida1 <= 1'b1;
        end else if (w_wr_a && MODE_A == 1) begin
            r_douta1  <= w_old_a;
            r_valida1 <= 1'b1;
        end else begin
            r_valida1 <= 1'b0;  // idle, out of range or NO_CHANGE: dout holds
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_doutb1  <= '0;
            r_validb1 <= 1'b0;
        end else if (w_vb && !w_wr_b) begin
            r_doutb1  <= w_old_b;
            r_validb1 <= 1'b1;
        end else if (w_wr_b && MODE_B == 0) begin
            r_doutb1  <= w_fin_b;
            r_validb1 <= 1'b1;
        end else if (w_wr_b && MODE_B == 1) begin
            r_doutb1  <= w_old_b;
            r_validb1 <= 1'b1;
        end else begin
            r_validb1 <= 1'b0;
        end
    end

`ifdef TDP_OUT_REG_EN
    // Second output stage. valid travels with its data.
    logic [RAM_WIDTH-1:0] r_douta2, r_doutb2;
    logic                 r_valida2, r_validb2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_douta2  <= '0;
            r_doutb2  <= '0;
            r_valida2 <= 1'b0;
            r_validb2 <= 1'b0;
        end else begin
            r_douta2  <= r_douta1;
            r_doutb2  <= r_doutb1;
            r_valida2 <= r_valida1;
            r_validb2 <= r_validb1;
        end
    end

    assign douta  = r_douta2;
    assign doutb  = r_doutb2;
    assign valida = r_valida2;
    assign validb = r_validb2;
`else
    assign douta  = r_douta1;
    assign doutb  = r_doutb1;
    assign valida = r_valida1;
    assign validb = r_validb1;
`endif

    // Collision monitor. Its timing is the same in both builds.
    logic        r_coll;
    logic [15:0] r_coll_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_coll     <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            r_coll <= w_coll;
            if (w_coll && (r_coll_cnt != 16'hFFFF)) begin
                r_coll_cnt <= r_coll_cnt + 16'd1;
            end
        end
    end

    assign coll     = r_coll;
    assign coll_cnt = r_coll_cnt;

endmodule

// File: tb/tb_tdp_bram_mode.sv
// ---------------------------------------------------------------------------
// tb_tdp_bram_mode
//
// Directed bench for tdp_bram_mode with the default modes: A is WRITE_FIRST,
// B is READ_FIRST, and port A wins byte conflicts. The depth is set to 1000
// so that addresses 1000..1023 are out of range. The bench follows the
// read latency of whichever build it is compiled with (TDP_OUT_REG_EN).
// ---------------------------------------------------------------------------
module tb_tdp_bram_mode;

    localparam int W  = 16;
    localparam int LG = 10;
`ifdef TDP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          ena, enb;
    logic [1:0]    wea, web;
    logic [LG-1:0] addra, addrb;
    logic [W-1:0]  dina, dinb;
    logic [W-1:0]  douta, doutb;
    logic          valida, validb;
    logic          coll;
    logic [15:0]   coll_cnt;

    tdp_bram_mode #(
        .RAM_WIDTH (16),
        .RAM_DEPTH (1000),
        .LOG       (10),
        .BYTE_W    (8),
        .MODE_A    (0),
        .MODE_B    (1),
        .COLL_PRIO (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .douta    (douta),
        .valida   (valida),
        .enb      (enb),
        .web      (web),
        .addrb    (addrb),
        .dinb     (dinb),
        .doutb    (doutb),
        .validb   (validb),
        .coll     (coll),
        .coll_cnt (coll_cnt)
    );

    // ---------------- scoreboard ----------------
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic         coll_s;
    logic [15:0]  cnt_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_rd(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk_rd(input string tag, input logic [W-1:0] obs);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            chk(tag, 32'(obs), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        ena = 1'b0; wea = '0; addra = '0; dina = '0;
        enb = 1'b0; web = '0; addrb = '0; dinb = '0;
    endtask

    task automatic drv_a(input logic [1:0] we, input logic [LG-1:0] a, input logic [W-1:0] d);
        ena = 1'b1; wea = we; addra = a; dina = d;
    endtask

    task automatic drv_b(input logic [1:0] we, input logic [LG-1:0] a, input logic [W-1:0] d);
        enb = 1'b1; web = we; addrb = a; dinb = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request cycle. The collision outputs are captured one edge after
    // the request. The ports are then idled while the data drains through
    // any extra output stage.
    task automatic cycle();
        step();
        coll_s = coll;
        cnt_s  = coll_cnt;
        idle();
        for (int i = 1; i < LAT; i++) step();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        chk("rst_douta",    32'(douta),    32'h0);
        chk("rst_doutb",    32'(doutb),    32'h0);
        chk("rst_valida",   32'(valida),   32'h0);
        chk("rst_validb",   32'(validb),   32'h0);
        chk("rst_coll",     32'(coll),     32'h0);
        chk("rst_coll_cnt", 32'(coll_cnt), 32'h0);
        rst_n = 1'b1;

        // 1: A writes BEEF @5, then B reads it back
        drv_a(2'b11, 10'd5, 16'hBEEF);
        cycle();
        exp_rd(16'hBEEF); chk_rd("t1_wf_douta", douta);
        chk("t1_valida", 32'(valida), 32'h1);
        chk("t1_no_coll", 32'(coll_s), 32'h0);
        drv_b(2'b00, 10'd5, 16'h0000);
        cycle();
        exp_rd(16'hBEEF); chk_rd("t1_rd_doutb", doutb);
        chk("t1_validb", 32'(validb), 32'h1);
        chk("t1_valida_idle", 32'(valida), 32'h0);
        exp_rd(16'hBEEF); chk_rd("t1_douta_hold", douta);

        // 2: byte enables, WRITE_FIRST on A and READ_FIRST on B
        drv_a(2'b11, 10'd7, 16'h1234);
        cycle();
        drv_a(2'b10, 10'd7, 16'hAB00);
        cycle();
        exp_rd(16'hAB34); chk_rd("t2_wf_merge_douta", douta);
        drv_b(2'b01, 10'd7, 16'h00CD);
        cycle();
        exp_rd(16'hAB34); chk_rd("t2_rf_doutb_old", doutb);
        chk("t2_validb", 32'(validb), 32'h1);
        chk("t2_no_coll", 32'(coll_s), 32'h0);
        drv_a(2'b00, 10'd7, 16'h0000);
        cycle();
        exp_rd(16'hABCD); chk_rd("t2_rd_merged", douta);

        // 3: write-write collision @9, then a partial-byte conflict
        drv_a(2'b11, 10'd9, 16'h0909);
        cycle();
        drv_a(2'b11, 10'd9, 16'h1111);
        drv_b(2'b11, 10'd9, 16'h2222);
        cycle();
        chk("t3_coll", 32'(coll_s), 32'h1);
        chk("t3_coll_cnt", 32'(cnt_s), 32'h1);
        exp_rd(16'h1111); chk_rd("t3_wf_final_douta", douta);
        exp_rd(16'h0909); chk_rd("t3_rf_old_doutb", doutb);
        drv_b(2'b00, 10'd9, 16'h0000);
        cycle();
        exp_rd(16'h1111); chk_rd("t3_rd_winner", doutb);
        chk("t3_coll_pulse_end", 32'(coll_s), 32'h0);
        drv_a(2'b01, 10'd9, 16'h00AA);
        drv_b(2'b11, 10'd9, 16'hBBCC);
        cycle();
        exp_rd(16'hBBAA); chk_rd("t3_byte_mix_douta", douta);
        exp_rd(16'h1111); chk_rd("t3_byte_mix_doutb", doutb);
        chk("t3_coll_cnt2", 32'(cnt_s), 32'h2);

        // 4: read-write collision returns old data, then idle holds dout
        drv_a(2'b11, 10'd3, 16'h0F0F);
        cycle();
        drv_a(2'b00, 10'd3, 16'h0000);
        drv_b(2'b11, 10'd3, 16'h5555);
        cycle();
        exp_rd(16'h0F0F); chk_rd("t4_rw_old_douta", douta);
        exp_rd(16'h0F0F); chk_rd("t4_rf_doutb", doutb);
        chk("t4_coll", 32'(coll_s), 32'h1);
        chk("t4_coll_cnt", 32'(cnt_s), 32'h3);
        cycle();
        exp_rd(16'h0F0F); chk_rd("t4_idle_hold", douta);
        chk("t4_idle_valida", 32'(valida), 32'h0);
        // a read-read on the same address is not a collision
        drv_a(2'b00, 10'd3, 16'h0000);
        drv_b(2'b00, 10'd3, 16'h0000);
        cycle();
        exp_rd(16'h5555); chk_rd("t4_rr_douta", douta);
        exp_rd(16'h5555); chk_rd("t4_rr_doutb", doutb);
        chk("t4_rr_no_coll", 32'(coll_s), 32'h0);
        chk("t4_rr_cnt", 32'(cnt_s), 32'h3);

        // out-of-range address: ignored, not a collision
        drv_a(2'b11, 10'd1010, 16'hDEAD);
        drv_b(2'b11, 10'd1010, 16'hBEEF);
        cycle();
        chk("oor_valida", 32'(valida), 32'h0);
        chk("oor_validb", 32'(validb), 32'h0);
        exp_rd(16'h5555); chk_rd("oor_douta_hold", douta);
        chk("oor_no_coll", 32'(coll_s), 32'h0);
        chk("oor_cnt", 32'(cnt_s), 32'h3);

        // 5: a write during reset is dropped
        drv_a(2'b11, 10'd2, 16'hA5A5);
        cycle();
        rst_n = 1'b0;
        drv_a(2'b11, 10'd2, 16'hFFFF);
        drv_b(2'b11, 10'd2, 16'h0000);
        step();
        chk("t5_rst_douta", 32'(douta), 32'h0);
        chk("t5_rst_valida", 32'(valida), 32'h0);
        chk("t5_rst_coll", 32'(coll), 32'h0);
        chk("t5_rst_cnt", 32'(coll_cnt), 32'h0);
        idle();
        rst_n = 1'b1;
        drv_a(2'b00, 10'd2, 16'h0000);
        cycle();
        exp_rd(16'hA5A5); chk_rd("t5_old_value", douta);
        chk("t5_cnt_zero", 32'(cnt_s), 32'h0);

        // 6: counter saturation under continuous collisions
        drv_a(2'b11, 10'd9, 16'h0001);
        drv_b(2'b11, 10'd9, 16'h0002);
        repeat (65534) @(posedge clk);
        #1;
        chk("t6_cnt_fffe", 32'(coll_cnt), 32'hFFFE);
        chk("t6_coll_held", 32'(coll), 32'h1);
        step();
        chk("t6_cnt_ffff", 32'(coll_cnt), 32'hFFFF);
        step();
        step();
        chk("t6_cnt_sat", 32'(coll_cnt), 32'hFFFF);
        idle();
        step();
        step();
        chk("t6_coll_drop", 32'(coll), 32'h0);
        chk("t6_cnt_sat_idle", 32'(coll_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
